// File: rtl/pn_shift_sequencer_if.sv
// Purpose: streaming handshake bundle between the shift sequencer, its
//          message source and the Benes network input stage.
// Signals:
//   in_valid/in_ready/in_data          message vector stream into the sequencer
//   out_valid/out_ready                operand handshake toward the network
//   out_data/out_sn/out_in             network indata, shift number, active size
// Modports:
//   slave  - sequencer side (consumes input stream, drives network operands)
//   master - environment side (drives input stream, consumes network operands)
interface pn_shift_sequencer_if #(
    parameter int unsigned Z  = 96,
    parameter int unsigned SW = 7
);
    logic          in_valid;
    logic          in_ready;
    logic [Z-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [Z-1:0]  out_data;
    logic [SW-1:0] out_sn;
    logic [SW-1:0] out_in;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sn, out_in
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sn, out_in
    );
endinterface

// File: rtl/pn_shift_sequencer.sv
// Purpose: feeds the LDPC Benes permutation network. Holds one base-matrix
//          row of circulant shifts, pairs each incoming Z-bit message with its
//          reduced shift and presents the pair through a registered
//          valid/ready stage. Null circulants are skipped without consuming data.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   cfg_we/cfg_addr/cfg_shift    shift-table write port (blocked while busy)
//   cfg_len, cfg_z               pass length and lifting size, sampled on start
//   start                        begin a row pass (ignored while busy)
//   busy, done                   pass in progress / one-cycle end-of-pass pulse
//   err                          sticky: a non-null shift >= 2z was seen
//   nif                          message input stream and network operand output
module pn_shift_sequencer #(
    parameter int unsigned Z     = 96,
    parameter int unsigned SW    = 7,
    parameter int unsigned DEPTH = 24,
    parameter int unsigned AW    = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [AW-1:0]          cfg_addr,
    input  logic [SW-1:0]          cfg_shift,
    input  logic [AW:0]            cfg_len,
    input  logic [SW-1:0]          cfg_z,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    pn_shift_sequencer_if.slave    nif
);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = SW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] idx_q, len_q, idx_next;
    logic [SW-1:0] z_q;
    logic          err_q, busy_q, done_q;
    logic          out_valid_q;
    logic [Z-1:0]  out_data_q;
    logic [SW-1:0] out_sn_q, out_in_q;
    logic [SW-1:0] tbl [DEPTH];

    logic [SW-1:0] entry_c, sn_c;
    logic [EW-1:0] e_ext, z_ext, z2_ext;
    logic          entry_null_c, over_c;
    logic          in_ready_c, accept_c, advance_c, start_c, wr_en_c;

    assign entry_c      = tbl[idx_q[AW-1:0]];
    assign entry_null_c = (entry_c == '1);
    assign idx_next     = idx_q + LW'(1);
    assign wr_en_c      = cfg_we && !(state_q == RUN || state_q == DRAIN) &&
                          ({1'b0, cfg_addr} < LW'(DEPTH));

    // Shift reduction into [0, z); anything at or beyond 2z is flagged and zeroed
    assign e_ext  = {1'b0, entry_c};
    assign z_ext  = {1'b0, z_q};
    assign z2_ext = {z_q, 1'b0};

    always_comb begin
        sn_c   = entry_c;
        over_c = 1'b0;
        if (e_ext >= z2_ext) begin
            sn_c   = '0;
            over_c = 1'b1;
        end else if (e_ext >= z_ext) begin
            sn_c = SW'(e_ext - z_ext);
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        accept_c   = 1'b0;
        advance_c  = 1'b0;
        start_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_c = 1'b1;
                    state_d = (cfg_len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (entry_null_c) begin
                    advance_c = 1'b1;
                end else begin
                    in_ready_c = !out_valid_q || nif.out_ready;
                    accept_c   = in_ready_c && nif.in_valid;
                    advance_c  = accept_c;
                end
                if (advance_c && (idx_next == len_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid_q || nif.out_ready) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with registered busy/done status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == RUN) || (state_d == DRAIN);
            done_q  <= (state_d == FIN);
        end
    end

    // Pass bookkeeping and network operand register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            len_q       <= '0;
            z_q         <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sn_q    <= '0;
            out_in_q    <= '0;
        end else begin
            if (start_c) begin
                len_q <= (cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len;
                z_q   <= cfg_z;
                idx_q <= '0;
                err_q <= 1'b0;
            end else if (advance_c) begin
                idx_q <= idx_next;
            end
            // A new accept refills the register; otherwise a taken operand empties it
            if (accept_c) begin
                out_valid_q <= 1'b1;
                out_data_q  <= nif.in_data;
                out_sn_q    <= sn_c;
                out_in_q    <= z_q;
                if (over_c) begin
                    err_q <= 1'b1;
                end
            end else if (nif.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Shift table; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            tbl[cfg_addr] <= cfg_shift;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign nif.in_ready  = in_ready_c;
    assign nif.out_valid = out_valid_q;
    assign nif.out_data  = out_data_q;
    assign nif.out_sn    = out_sn_q;
    assign nif.out_in    = out_in_q;
endmodule

// File: tb/tb_pn_shift_sequencer.sv
// Testbench for pn_shift_sequencer: directed vector table for shift reduction
// plus hand-written sequences for skips, stalls, zero-length passes and reset.
module tb_pn_shift_sequencer;
    localparam int unsigned Z     = 96;
    localparam int unsigned SW    = 7;
    localparam int unsigned DEPTH = 24;
    localparam int unsigned AW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [SW-1:0] cfg_shift;
    logic [AW:0]   cfg_len;
    logic [SW-1:0] cfg_z;
    logic          start;
    logic          busy, done, err;

    always #5 clk = ~clk;

    pn_shift_sequencer_if #(.Z(Z), .SW(SW)) bus ();

    pn_shift_sequencer #(.Z(Z), .SW(SW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_shift (cfg_shift),
        .cfg_len   (cfg_len),
        .cfg_z     (cfg_z),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .nif       (bus)
    );

    typedef struct {
        logic [Z-1:0]  data;
        logic [SW-1:0] sn;
    } out_t;

    typedef struct {
        int z;
        int sh;
        int sn;
        int er;
    } vec_t;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    int acc_cnt = 0;
    int acc_edge = 0;
    int start_edge = 0;
    out_t exp_q[$];
    logic [Z-1:0] src[$];
    logic [SW-1:0] exp_in = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [Z-1:0] rnd();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [Z-1:0] d, input int sn);
        out_t t;
        t.data = d;
        t.sn   = SW'(sn);
        src.push_back(d);
        exp_q.push_back(t);
    endtask

    task automatic wr(input int addr, input int val);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(addr);
        cfg_shift = SW'(val);
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic start_pass(input int len, input int z, input bit we, input int addr, input int val);
        start     = 1'b1;
        cfg_len   = (AW+1)'(len);
        cfg_z     = SW'(z);
        cfg_we    = we;
        cfg_addr  = AW'(addr);
        cfg_shift = SW'(val);
        exp_in    = SW'(z);
        cyc();
        start_edge = cyc_n;
        start  = 1'b0;
        cfg_we = 1'b0;
    endtask

    // Feeds src until done, with optional out_ready stall window and a
    // start/cfg_we poke on the first RUN cycle (must both be ignored).
    task automatic run_pass(input int stall_at, input int stall_n, input bit poke,
                            output int dones, output int done_edge);
        int base, k, post;
        base = acc_cnt;
        dones = 0;
        done_edge = -1;
        post = 0;
        for (int c = 0; c < 64 && post < 3; c++) begin
            k = acc_cnt - base;
            bus.in_valid  = (k < src.size());
            bus.in_data   = (k < src.size()) ? src[k] : '0;
            bus.out_ready = !(c >= stall_at && c < stall_at + stall_n);
            if (poke && c == 0) begin
                start     = 1'b1;
                cfg_len   = '0;
                cfg_we    = 1'b1;
                cfg_addr  = '0;
                cfg_shift = SW'(11);
            end
            cyc();
            start  = 1'b0;
            cfg_we = 1'b0;
            if (done) begin
                dones++;
                if (done_edge < 0) done_edge = cyc_n;
            end
            if (dones > 0) post++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("accepted", 128'(acc_cnt - base), 128'(src.size()));
        chk("outputs_left", 128'(exp_q.size()), 128'(0));
        src.delete();
        exp_q.delete();
    endtask

    initial forever begin
        @(posedge clk);
        cyc_n++;
    end

    // Monitor: counts accepts, scores transfers, checks stall stability
    initial begin : mon
        logic          hold;
        logic [Z-1:0]  pd;
        logic [SW-1:0] ps, pi;
        out_t          e;
        hold = 1'b0;
        pd = '0;
        ps = '0;
        pi = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", 128'(bus.out_valid), 128'(1));
                    chk("hold_data", 128'(bus.out_data), 128'(pd));
                    chk("hold_sn", 128'(bus.out_sn), 128'(ps));
                    chk("hold_in", 128'(bus.out_in), 128'(pi));
                end
                if (bus.in_valid && bus.in_ready) begin
                    acc_cnt++;
                    acc_edge = cyc_n + 1;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_output", 128'(bus.out_valid), 128'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", 128'(bus.out_data), 128'(e.data));
                        chk("out_sn", 128'(bus.out_sn), 128'(e.sn));
                        chk("out_in", 128'(bus.out_in), 128'(exp_in));
                    end
                end
                hold = bus.out_valid && !bus.out_ready;
                pd = bus.out_data;
                ps = bus.out_sn;
                pi = bus.out_in;
            end
        end
    end

    initial begin
        vec_t vt[12];
        int dones, dedge, base0;
        logic [Z-1:0] d;

        vt = '{'{96, 5, 5, 0}, '{96, 0, 0, 0}, '{96, 95, 95, 0}, '{96, 100, 4, 0},
               '{96, 126, 30, 0}, '{52, 60, 8, 0}, '{52, 103, 51, 0}, '{52, 104, 0, 1},
               '{1, 0, 0, 0}, '{1, 1, 0, 0}, '{1, 2, 0, 1}, '{63, 125, 62, 0}};

        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_shift = '0; cfg_len = '0; cfg_z = '0; start = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        repeat (3) cyc();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out_data", 128'(bus.out_data), 128'(0));
        chk("rst_out_sn", 128'(bus.out_sn), 128'(0));
        chk("rst_out_in", 128'(bus.out_in), 128'(0));
        chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
        rst_n = 1'b1;
        cyc();

        // Full-rate pass; mid-pass start/cfg_we must be ignored
        wr(0, 5); wr(1, 0); wr(2, 95);
        push_exp(rnd(), 5); push_exp(rnd(), 0); push_exp(rnd(), 95);
        start_pass(3, 96, 1'b0, 0, 0);
        chk("t1_busy", 128'(busy), 128'(1));
        run_pass(100, 0, 1'b1, dones, dedge);
        chk("t1_done_cnt", 128'(dones), 128'(1));
        chk("t1_done_after_acc", 128'(dedge - acc_edge), 128'(1));
        chk("t1_no_bubble", 128'(dedge - start_edge), 128'(4));
        push_exp(rnd(), 5);
        start_pass(1, 96, 1'b0, 0, 0);
        run_pass(100, 0, 1'b0, dones, dedge);
        chk("busy_write_ignored_done", 128'(dones), 128'(1));

        // Single-entry reduction vectors, table write coincident with start
        foreach (vt[i]) begin
            d = rnd();
            push_exp(d, vt[i].sn);
            start_pass(1, vt[i].z, 1'b1, 0, vt[i].sh);
            run_pass(100, 0, 1'b0, dones, dedge);
            chk($sformatf("vec%0d_done", i), 128'(dones), 128'(1));
            chk($sformatf("vec%0d_err", i), 128'(err), 128'(vt[i].er));
        end

        // Two null entries, then one real entry
        wr(0, 127); wr(1, 127); wr(2, 7);
        d = rnd();
        push_exp(d, 7);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        base0 = acc_cnt;
        start_pass(3, 96, 1'b0, 0, 0);
        chk("t2_skip0_in_ready", 128'(bus.in_ready), 128'(0));
        cyc();
        chk("t2_skip1_in_ready", 128'(bus.in_ready), 128'(0));
        cyc();
        chk("t2_real_in_ready", 128'(bus.in_ready), 128'(1));
        chk("t2_nothing_consumed", 128'(acc_cnt - base0), 128'(0));
        run_pass(100, 0, 1'b0, dones, dedge);
        chk("t2_done_cnt", 128'(dones), 128'(1));

        // z=52 reductions with overflow on the last entry
        wr(0, 60); wr(1, 103); wr(2, 104);
        push_exp(rnd(), 8); push_exp(rnd(), 51); push_exp(rnd(), 0);
        start_pass(3, 52, 1'b0, 0, 0);
        run_pass(100, 0, 1'b0, dones, dedge);
        chk("t3_done_cnt", 128'(dones), 128'(1));
        chk("t3_err_set", 128'(err), 128'(1));

        // Zero-length pass: clears err, immediate done, no input consumed
        bus.in_valid = 1'b1;
        bus.in_data  = rnd();
        base0 = acc_cnt;
        start_pass(0, 52, 1'b0, 0, 0);
        chk("t5_err_cleared", 128'(err), 128'(0));
        chk("t5_done", 128'(done), 128'(1));
        chk("t5_busy", 128'(busy), 128'(0));
        chk("t5_in_ready", 128'(bus.in_ready), 128'(0));
        cyc();
        chk("t5_done_once", 128'(done), 128'(0));
        chk("t5_no_accept", 128'(acc_cnt - base0), 128'(0));
        bus.in_valid = 1'b0;

        // Downstream stall mid-pass
        wr(0, 10); wr(1, 20); wr(2, 30); wr(3, 40);
        push_exp(rnd(), 10); push_exp(rnd(), 20); push_exp(rnd(), 30); push_exp(rnd(), 40);
        start_pass(4, 96, 1'b0, 0, 0);
        run_pass(2, 4, 1'b0, dones, dedge);
        chk("t4_done_cnt", 128'(dones), 128'(1));

        // Reset in the middle of a pass
        wr(0, 1); wr(1, 2); wr(2, 3);
        start_pass(3, 96, 1'b0, 0, 0);
        bus.in_valid  = 1'b1;
        bus.in_data   = rnd();
        bus.out_ready = 1'b0;
        cyc();
        cyc();
        chk("t6_pre_valid", 128'(bus.out_valid), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("t6_rst_busy", 128'(busy), 128'(0));
        chk("t6_rst_in_ready", 128'(bus.in_ready), 128'(0));
        chk("t6_rst_out_data", 128'(bus.out_data), 128'(0));
        cyc();
        rst_n = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc();
        wr(0, 1); wr(1, 2); wr(2, 3);
        push_exp(rnd(), 1); push_exp(rnd(), 2); push_exp(rnd(), 3);
        start_pass(3, 96, 1'b0, 0, 0);
        run_pass(100, 0, 1'b0, dones, dedge);
        chk("t6_fresh_done_cnt", 128'(dones), 128'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
